regfile_scb: RTL
================

Name: regfile_scb

Overview:
Parametrised multi-read-port register file with an integrated busy-bit scoreboard and a write-to-read bypass. It sits in the decode stage of the pipelined core. Decode reads NREAD source operands and learns whether each one is still owed by an in-flight producer. Issue marks a destination as pending; writeback delivers data and clears the pending mark.

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of architectural registers (power of two, >= 2)
NREAD, 2, number of combinational read ports (1..4)
ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never busy
AW, $clog2(NREG), address width (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
rs_addr  in  NREAD*AW  packed read addresses; port i uses bits [i*AW +: AW]
rs_data  out  NREAD*XLEN  packed read data; port i uses bits [i*XLEN +: XLEN]
rs_busy  out  NREAD  bit i set means port i's register has a pending producer
iss_en  in  1  issue strobe: mark iss_rd busy
iss_rd  in  AW  destination register of the issuing instruction
wb_en  in  1  writeback strobe
wb_addr  in  AW  writeback register
wb_data  in  XLEN  writeback data
flush  in  1  clear all busy bits (register contents kept)
any_busy  out  1  OR of all busy bits

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset), sampled on the clk rising edge.
- Reset has priority over every other input. It clears all NREG registers to 0 and all busy bits to 0.
- Outputs are combinational from state. In the cycle after reset, every rs_data reads 0, rs_busy is 0 and any_busy is 0.
- Write: on a rising edge with wb_en=1, rf[wb_addr] <= wb_data and busy[wb_addr] <= 0.
- Exception to the write rule: if ZERO_REG=1 and wb_addr=0, nothing changes.
- Issue: on a rising edge with iss_en=1 and flush=0, busy[iss_rd] <= 1. This is ignored for iss_rd=0 when ZERO_REG=1.
- Same register, same cycle, iss_en and wb_en both asserted: data is written and the busy bit ends at 1. The new producer wins (WAW ordering).
- Flush: on a rising edge with flush=1, all busy bits go to 0 and iss_en is ignored that cycle. A wb_en in the same cycle still writes data.
- Read, no bypass hit: rs_data[i] = rf[rs_addr[i]] and rs_busy[i] = busy[rs_addr[i]].
- Bypass hit: wb_en=1 and wb_addr == rs_addr[i] (and not the zero register). Then rs_data[i] = wb_data and rs_busy[i] = 0 in the same cycle. This is zero latency; decode never needs a second read.
- Zero register with ZERO_REG=1: rs_data[i] = 0 and rs_busy[i] = 0 regardless of wb or bypass.
- Independent ports: any number of read ports may address the same register. Each port returns identical data and busy.
- Iss_en does not affect reads in the same cycle. Busy becomes visible the cycle after issue.
- any_busy is the OR of the registered busy vector only. Bypass has no effect on it.
- Timing: no state machine beyond the NREG-bit busy vector. Write latency is 1 cycle and read latency is 0.
- Out-of-range addresses cannot occur because NREG = 2^AW.

Decomposition:
- Shared package regfile_pkg holds the default XLEN/NREG/NREAD constants and the typedefs reg_addr_t (logic [AW-1:0]) and reg_data_t (logic [XLEN-1:0]). The core datapath imports the same typedefs.
- Natural sub-module: busy_scoreboard (NREG, ZERO_REG). It owns the busy vector with its set/clear/flush/reset priority and drives any_busy and per-address busy lookup.
- regfile_scb instantiates busy_scoreboard and keeps the storage array, the read multiplexers and the bypass logic itself.

Test Plan:
1. Reset check: assert reset 1 cycle with random prior contents, then read all 32 addresses over ports 0/1 -> every rs_data=0, rs_busy=0, any_busy=0.
2. Write/read and zero register: wb_en, wb_addr=5, wb_data=0xDEADBEEF, then read port 1 addr 5 next cycle -> 0xDEADBEEF. Write 0x1234 to addr 0, then read addr 0 -> 0.
3. Bypass: rf[7]=0x11; same cycle wb_en, wb_addr=7, wb_data=0x22, rs_addr port 0=7 -> rs_data[0]=0x22 combinationally, rs_busy[0]=0. Next cycle without wb -> 0x22.
4. Scoreboard life cycle: iss_en, iss_rd=9 -> next cycle rs_busy for addr 9 =1 and any_busy=1. wb_en to 9 with 0xAA -> bypass shows 0xAA, busy=0 that cycle; busy stays 0 after.
5. Simultaneous issue and writeback to addr 3, then flush with iss_en to addr 4 -> after cycle 1 busy[3]=1 and rf[3]=wb_data. After flush, busy[3]=busy[4]=0 and any_busy=0.
6. Reset mid-operation: busy on 2/6/8 and wb_en pending in the reset cycle -> all busy cleared, rf[wb_addr]=0 (reset beats write). Repeat the scenario with NREAD=4, XLEN=64, NREG=16.

Source files
------------

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
//   Shared constants and typedefs for the decode-stage register file and its
//   busy-bit scoreboard. The defaults describe the standard core
//   configuration: 32 x 32-bit registers and two read ports.
//   The typedefs are sized for the default configuration. Datapath code
//   built for the default core uses them directly.
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREG_DEF  = 32;
    localparam int unsigned NREAD_DEF = 2;
    localparam int unsigned AW_DEF    = $clog2(NREG_DEF);

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] reg_data_t;

endpackage : regfile_pkg

// File: rtl/regfile_scb_busy_scoreboard.sv
// ---------------------------------------------------------------------------
// busy_scoreboard
//   Owns the NREG-bit busy vector. Each bit means "an in-flight producer
//   still owes this register". The module also provides a busy lookup per
//   read port and the OR of all busy bits.
//
//   Update rules, applied in order of increasing priority:
//     clear  - writeback clears the bit of the register it writes
//     issue  - issue sets the bit of its destination, so a same-cycle
//              writeback to the same register loses (WAW ordering)
//     flush  - clears every bit and suppresses issue
//     reset  - clears every bit
//   With ZERO_REG=1, register 0 is never set, so it always reads as not busy.
//
// Ports
//   clk_i          rising-edge clock
//   reset_i        synchronous active-high reset
//   iss_en_i       issue strobe
//   iss_rd_i       issue destination register
//   clr_en_i       writeback strobe (clears busy)
//   clr_addr_i     writeback register
//   flush_i        clear all busy bits, ignore issue
//   lookup_addr_i  packed per-port lookup addresses (port p at [p*AW +: AW])
//   lookup_busy_o  registered busy bit of each looked-up register
//   any_busy_o     OR of the registered busy vector
// ---------------------------------------------------------------------------
module busy_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREG     = NREG_DEF,
    parameter bit          ZERO_REG = 1'b1,
    parameter int unsigned NREAD    = NREAD_DEF,
    parameter int unsigned AW       = $clog2(NREG)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  iss_en_i,
    input  logic [AW-1:0]         iss_rd_i,
    input  logic                  clr_en_i,
    input  logic [AW-1:0]         clr_addr_i,
    input  logic                  flush_i,
    input  logic [NREAD*AW-1:0]   lookup_addr_i,
    output logic [NREAD-1:0]      lookup_busy_o,
    output logic                  any_busy_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            iss_ok;
    logic            clr_ok;

    assign iss_ok = iss_en_i && !(ZERO_REG && (iss_rd_i == '0));
    assign clr_ok = clr_en_i && !(ZERO_REG && (clr_addr_i == '0));

    // The later assignments override the earlier ones. This gives the
    // priority order: issue beats clear, and flush beats both.
    always_comb begin
        busy_d = busy_q;
        if (clr_ok) begin
            busy_d[clr_addr_i] = 1'b0;
        end
        if (flush_i) begin
            busy_d = '0;
        end else if (iss_ok) begin
            busy_d[iss_rd_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        lookup_busy_o = '0;
        for (int unsigned p = 0; p < NREAD; p++) begin
            lookup_busy_o[p] = busy_q[lookup_addr_i[p*AW +: AW]];
        end
    end

    assign any_busy_o = |busy_q;

endmodule : busy_scoreboard

// File: rtl/regfile_scb.sv
// ---------------------------------------------------------------------------
// regfile_scb
//   Decode-stage register file with NREAD combinational read ports, an
//   integrated busy-bit scoreboard and a write-to-read bypass.
//   Decode reads its source operands and learns in the same cycle whether
//   each operand is still owed by an in-flight producer. Issue marks a
//   destination as pending. Writeback delivers the data and clears the
//   pending mark.
//
//   A writeback is visible on a matching read port in the same cycle, with
//   busy shown as 0. Decode therefore never needs a second read. With
//   ZERO_REG=1, register 0 reads as 0, is never busy and ignores writes.
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous active-high reset; clears data and busy bits
//   rs_addr   packed read addresses, port i at [i*AW +: AW]
//   rs_data   packed read data, port i at [i*XLEN +: XLEN]
//   rs_busy   per-port pending-producer flag
//   iss_en    issue strobe; iss_rd becomes busy next cycle
//   iss_rd    issue destination register
//   wb_en     writeback strobe
//   wb_addr   writeback register
//   wb_data   writeback data
//   flush     clear all busy bits; register contents are kept
//   any_busy  OR of the registered busy vector (bypass does not affect it)
// ---------------------------------------------------------------------------
module regfile_scb
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned NREG     = NREG_DEF,
    parameter int unsigned NREAD    = NREAD_DEF,
    parameter bit          ZERO_REG = 1'b1,
    parameter int unsigned AW       = $clog2(NREG)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREAD*AW-1:0]     rs_addr,
    output logic [NREAD*XLEN-1:0]   rs_data,
    output logic [NREAD-1:0]        rs_busy,
    input  logic                    iss_en,
    input  logic [AW-1:0]           iss_rd,
    input  logic                    wb_en,
    input  logic [AW-1:0]           wb_addr,
    input  logic [XLEN-1:0]         wb_data,
    input  logic                    flush,
    output logic                    any_busy
);

    logic [XLEN-1:0]  rf_q [NREG];
    logic             wr_ok;
    logic [NREAD-1:0] sb_busy;

    busy_scoreboard #(
        .NREG     (NREG),
        .ZERO_REG (ZERO_REG),
        .NREAD    (NREAD),
        .AW       (AW)
    ) u_busy (
        .clk_i         (clk),
        .reset_i       (reset),
        .iss_en_i      (iss_en),
        .iss_rd_i      (iss_rd),
        .clr_en_i      (wb_en),
        .clr_addr_i    (wb_addr),
        .flush_i       (flush),
        .lookup_addr_i (rs_addr),
        .lookup_busy_o (sb_busy),
        .any_busy_o    (any_busy)
    );

    assign wr_ok = wb_en && !(ZERO_REG && (wb_addr == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wr_ok) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    // Per-port read with bypass. The zero register is checked first, so a
    // writeback to register 0 never shows up on a read port when ZERO_REG=1.
    always_comb begin
        rs_data = '0;
        rs_busy = '0;
        for (int unsigned p = 0; p < NREAD; p++) begin
            logic [AW-1:0] rd_addr;
            rd_addr = rs_addr[p*AW +: AW];
            if (ZERO_REG && (rd_addr == '0)) begin
                rs_data[p*XLEN +: XLEN] = '0;
                rs_busy[p]              = 1'b0;
            end else if (wb_en && (wb_addr == rd_addr)) begin
                rs_data[p*XLEN +: XLEN] = wb_data;
                rs_busy[p]              = 1'b0;
            end else begin
                rs_data[p*XLEN +: XLEN] = rf_q[rd_addr];
                rs_busy[p]              = sb_busy[p];
            end
        end
    end

endmodule : regfile_scb
